// File: rtl/ad7864_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ad7864_rd_ctrl                                                |
// | Brief    : AD7864 read-side controller with double-buffered DSP port     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ad7864_rd_ctrl #(
   parameter int NCH     = 4,
   parameter int DW      = 12,
   parameter int RD_LOW  = 3,
   parameter int RD_HIGH = 2,
   parameter int INT_LEN = 4
) (
   input  logic          clkin,
   input  logic          rst_bar,
   input  logic          ad_busy,
   input  logic [DW-1:0] ad_db,
   output logic          ad_cs_bar,
   output logic          ad_rd_bar,
   input  logic [1:0]    dsp_addr,
   output logic [DW-1:0] dsp_data,
   output logic          dsp_valid,
   input  logic          dsp_ack,
   output logic          dsp_int_bar,
   output logic          ovr
);

   localparam int c_cmax = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
   localparam int c_cw   = $clog2(c_cmax + 1);
   localparam int c_iw   = $clog2(INT_LEN + 1);

   localparam logic [c_cw-1:0] c_lo_last  = c_cw'(RD_LOW - 1);
   localparam logic [c_cw-1:0] c_hi_last  = c_cw'(RD_HIGH - 1);
   localparam logic [c_iw-1:0] c_int_len  = c_iw'(INT_LEN);
   localparam logic [c_iw-1:0] c_int_one  = c_iw'(1);
   localparam logic [1:0]      c_last_idx = 2'(NCH - 1);
   localparam logic [2:0]      c_nch      = 3'(NCH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD_LO = 2'd1,
      S_RD_HI = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [1:0]        r_idx;
   logic [c_cw-1:0]   r_cnt;
   logic [c_iw-1:0]   r_int_cnt;
   logic              r_cs_bar;
   logic              r_rd_bar;
   logic              r_int_bar;
   logic              r_valid;
   logic              r_ovr;
   logic              r_busy_s1;
   logic              r_busy_s2;
   logic              r_busy_prev;
   logic [DW-1:0]     r_shadow [4];
   logic [DW-1:0]     r_obuf   [4];
   logic              w_busy_fall;

   assign w_busy_fall = r_busy_prev & ~r_busy_s2;

   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_int_cnt   <= '0;
         r_cs_bar    <= 1'b1;
         r_rd_bar    <= 1'b1;
         r_int_bar   <= 1'b1;
         r_valid     <= 1'b0;
         r_ovr       <= 1'b0;
         r_busy_s1   <= 1'b0;
         r_busy_s2   <= 1'b0;
         r_busy_prev <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_shadow[i] <= '0;
            r_obuf[i]   <= '0;
         end
      end else begin
         r_busy_s1   <= ad_busy;
         r_busy_s2   <= r_busy_s1;
         r_busy_prev <= r_busy_s2;

         if (dsp_ack) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
         end

         if (r_int_cnt != '0) begin
            r_int_cnt <= r_int_cnt - 1'b1;
            if (r_int_cnt == c_int_one)
               r_int_bar <= 1'b1;
         end

         // A conversion finishing while we are still busy reading is lost.
         if (w_busy_fall && (r_state != S_IDLE))
            r_ovr <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_busy_fall) begin
                  r_state  <= S_RD_LO;
                  r_idx    <= '0;
                  r_cnt    <= '0;
                  r_cs_bar <= 1'b0;
                  r_rd_bar <= 1'b0;
               end
            end
            S_RD_LO: begin
               if (r_cnt == c_lo_last) begin
                  r_shadow[r_idx] <= ad_db;
                  r_cnt           <= '0;
                  r_rd_bar        <= 1'b1;
                  r_state         <= S_RD_HI;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RD_HI: begin
               if (r_cnt == c_hi_last) begin
                  r_cnt <= '0;
                  if (r_idx == c_last_idx) begin
                     r_cs_bar <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_idx    <= r_idx + 2'd1;
                     r_rd_bar <= 1'b0;
                     r_state  <= S_RD_LO;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               for (int i = 0; i < 4; i++)
                  r_obuf[i] <= r_shadow[i];
               r_valid   <= 1'b1;
               // A same-cycle ack consumes the old frame, so no overrun.
               if (r_valid && !dsp_ack)
                  r_ovr <= 1'b1;
               r_int_bar <= 1'b0;
               r_int_cnt <= c_int_len;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ad_cs_bar   = r_cs_bar;
   assign ad_rd_bar   = r_rd_bar;
   assign dsp_int_bar = r_int_bar;
   assign dsp_valid   = r_valid;
   assign ovr         = r_ovr;
   assign dsp_data    = ({1'b0, dsp_addr} < c_nch) ? r_obuf[dsp_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ad7864_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ad7864_rd_ctrl                                             |
// | Brief    : Directed/randomised self-checking bench for ad7864_rd_ctrl    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ad7864_rd_ctrl;

   localparam int DW    = 12;
   localparam int NCH_A = 4;
   localparam int RLO_A = 3;
   localparam int RHI_A = 2;
   localparam int NCH_B = 2;
   localparam int RLO_B = 1;
   localparam int RHI_B = 1;
   localparam int INTL  = 4;

   logic          clkin   = 1'b0;
   logic          rst_bar = 1'b0;
   logic          busy_a  = 1'b0, busy_b = 1'b0;
   logic          ack_a   = 1'b0, ack_b  = 1'b0;
   logic [1:0]    addr_a  = 2'd0, addr_b = 2'd0;
   logic [DW-1:0] db_a    = '0,   db_b   = '0;
   logic          cs_a, rd_a, int_a, valid_a, ovr_a;
   logic          cs_b, rd_b, int_b, valid_b, ovr_b;
   logic [DW-1:0] data_a, data_b;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] words [4];
   logic [DW-1:0] m_buf [2][4];
   logic          m_valid [2];
   logic          m_ovr   [2];

   ad7864_rd_ctrl #(.NCH(NCH_A), .DW(DW), .RD_LOW(RLO_A), .RD_HIGH(RHI_A), .INT_LEN(INTL)) u_dut_a (
      .clkin(clkin), .rst_bar(rst_bar), .ad_busy(busy_a), .ad_db(db_a),
      .ad_cs_bar(cs_a), .ad_rd_bar(rd_a), .dsp_addr(addr_a), .dsp_data(data_a),
      .dsp_valid(valid_a), .dsp_ack(ack_a), .dsp_int_bar(int_a), .ovr(ovr_a));

   ad7864_rd_ctrl #(.NCH(NCH_B), .DW(DW), .RD_LOW(RLO_B), .RD_HIGH(RHI_B), .INT_LEN(INTL)) u_dut_b (
      .clkin(clkin), .rst_bar(rst_bar), .ad_busy(busy_b), .ad_db(db_b),
      .ad_cs_bar(cs_b), .ad_rd_bar(rd_b), .dsp_addr(addr_b), .dsp_data(data_b),
      .dsp_valid(valid_b), .dsp_ack(ack_b), .dsp_int_bar(int_b), .ovr(ovr_b));

   always #5 clkin = ~clkin;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic get_cs(int s);    return (s != 0) ? cs_b    : cs_a;    endfunction
   function automatic logic get_rd(int s);    return (s != 0) ? rd_b    : rd_a;    endfunction
   function automatic logic get_int(int s);   return (s != 0) ? int_b   : int_a;   endfunction
   function automatic logic get_valid(int s); return (s != 0) ? valid_b : valid_a; endfunction
   function automatic logic get_ovr(int s);   return (s != 0) ? ovr_b   : ovr_a;   endfunction
   function automatic logic [DW-1:0] get_data(int s); return (s != 0) ? data_b : data_a; endfunction

   task automatic set_busy(input int s, input logic v); if (s != 0) busy_b = v; else busy_a = v; endtask
   task automatic set_ack(input int s, input logic v);  if (s != 0) ack_b  = v; else ack_a  = v; endtask
   task automatic set_db(input int s, input logic [DW-1:0] v); if (s != 0) db_b = v; else db_a = v; endtask
   task automatic set_addr(input int s, input logic [1:0] v);  if (s != 0) addr_b = v; else addr_a = v; endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_valid[s] = 1'b0;
         m_ovr[s]   = 1'b0;
         for (int i = 0; i < 4; i++) m_buf[s][i] = '0;
      end
   endtask

   task automatic read_check(input int s, input string tag);
      int nch;
      nch = (s != 0) ? NCH_B : NCH_A;
      for (int a = 0; a < 4; a++) begin
         set_addr(s, 2'(a));
         #1;
         check($sformatf("%s_data%0d", tag, a), 32'(get_data(s)),
               (a < nch) ? 32'(m_buf[s][a]) : 32'd0);
      end
   endtask

   task automatic status_check(input int s, input string tag);
      check({tag, "_valid"}, 32'(get_valid(s)), 32'(m_valid[s]));
      check({tag, "_ovr"},   32'(get_ovr(s)),   32'(m_ovr[s]));
      read_check(s, tag);
   endtask

   task automatic do_ack(input int s, input string tag);
      set_ack(s, 1'b1);
      @(posedge clkin); #1;
      set_ack(s, 1'b0);
      m_valid[s] = 1'b0;
      m_ovr[s]   = 1'b0;
      check({tag, "_ack_valid"}, 32'(get_valid(s)), 32'(m_valid[s]));
      check({tag, "_ack_ovr"},   32'(get_ovr(s)),   32'(m_ovr[s]));
   endtask

   // mode 0: plain, 1: ack during frame hand-over, 2: extra BUSY fall in 2nd strobe, 3: reset in 3rd strobe
   task automatic conv(input int s, input int mode, input string tag);
      int nch, rlo, rhi, k, first_fall, last_fall, spacing_bad, width_bad, run;
      int cs_low, int_low, cs_rise, int_fall, inj;
      logic prd, pcs, pint, rd, cs, ib, ack_on;
      nch = (s != 0) ? NCH_B : NCH_A;
      rlo = (s != 0) ? RLO_B : RLO_A;
      rhi = (s != 0) ? RHI_B : RHI_A;
      set_busy(s, 1'b1);
      repeat ((s != 0) ? 5 : 20) @(posedge clkin);
      #1 set_busy(s, 1'b0);
      k = 0; first_fall = -1; last_fall = -1; spacing_bad = 0; width_bad = 0; run = 0;
      cs_low = 0; int_low = 0; cs_rise = -1; int_fall = -1; inj = -1; ack_on = 1'b0;
      prd = 1'b1; pcs = 1'b1; pint = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clkin); #1;
         if (ack_on) begin set_ack(s, 1'b0); ack_on = 1'b0; end
         rd = get_rd(s); cs = get_cs(s); ib = get_int(s);
         if (!rd && prd) begin
            if (first_fall < 0) first_fall = c;
            else if (c - last_fall != rlo + rhi) spacing_bad++;
            last_fall = c;
            if (k < 4) set_db(s, words[k]);
            k++;
            if (mode == 2 && k == 2) begin set_busy(s, 1'b1); inj = c; end
            if (mode == 3 && k == 3) begin
               #3 rst_bar = 1'b0;
               #1;
               check({tag, "_async_cs"}, 32'(get_cs(s)), 32'd1);
               check({tag, "_async_rd"}, 32'(get_rd(s)), 32'd1);
               @(posedge clkin); @(posedge clkin); #1;
               rst_bar = 1'b1;
               model_reset();
               return;
            end
         end
         if (mode == 2 && inj > 0 && c == inj + 3) set_busy(s, 1'b0);
         if (rd && !prd) begin
            if (run != rlo) width_bad++;
            set_db(s, DW'($urandom));
         end
         run = rd ? 0 : run + 1;
         if (!cs) cs_low++;
         if (cs && !pcs) begin
            cs_rise = c;
            if (mode == 1) begin set_ack(s, 1'b1); ack_on = 1'b1; end
         end
         if (!ib) int_low++;
         if (!ib && pint && int_fall < 0) int_fall = c;
         prd = rd; pcs = cs; pint = ib;
      end
      check({tag, "_latency"},   32'(first_fall),  32'd3);
      check({tag, "_strobes"},   32'(k),           32'(nch));
      check({tag, "_width_bad"}, 32'(width_bad),   32'd0);
      check({tag, "_space_bad"}, 32'(spacing_bad), 32'd0);
      check({tag, "_cs_low"},    32'(cs_low),      32'(nch * (rlo + rhi)));
      check({tag, "_int_low"},   32'(int_low),     32'(INTL));
      check({tag, "_int_start"}, 32'(int_fall),    32'(cs_rise + 1));
      begin
         logic ackd;
         ackd = (mode == 1);
         m_ovr[s]   = (m_ovr[s] & ~ackd) | (m_valid[s] & ~ackd) | (mode == 2);
         m_valid[s] = 1'b1;
         for (int i = 0; i < nch; i++) m_buf[s][i] = words[i];
      end
      status_check(s, tag);
   endtask

   task automatic rand_words();
      for (int i = 0; i < 4; i++) words[i] = DW'($urandom);
   endtask

   initial begin
      model_reset();
      #12;
      check("rst_cs",    32'(cs_a),    32'd1);
      check("rst_rd",    32'(rd_a),    32'd1);
      check("rst_int",   32'(int_a),   32'd1);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_ovr",   32'(ovr_a),   32'd0);
      check("rst_data0", 32'(data_a),  32'd0);
      check("rst_cs_b",  32'(cs_b),    32'd1);
      #11 rst_bar = 1'b1;
      @(posedge clkin); #1;

      words[0] = 12'h111; words[1] = 12'h222; words[2] = 12'h333; words[3] = 12'h444;
      conv(0, 0, "t1");

      rand_words();
      conv(0, 0, "t2");
      do_ack(0, "t2");

      rand_words();
      conv(0, 0, "t3a");
      rand_words();
      conv(0, 1, "t3b");

      do_ack(0, "t4");
      rand_words();
      conv(0, 2, "t4");

      rand_words();
      conv(0, 3, "t5");
      status_check(0, "t5_post");
      rand_words();
      conv(0, 0, "t5_next");

      rand_words();
      conv(1, 0, "t6a");
      rand_words();
      conv(1, 0, "t6b");
      do_ack(1, "t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ad7864_rd_ctrl.md
Name: ad7864_rd_ctrl

Overview:
Read-side controller for the AD7864 four-channel ADC. It waits for the end of each conversion, signalled by a falling edge on BUSY, then reads NCH channel words off the shared parallel data bus using CS/RD strobes. It double-buffers the words and signals the DSP with a valid flag and an interrupt pulse. It runs alongside the conversion/clock driver in the same CPLD, and the DSP reads the results through a small addressed read port.

Parameters:
NCH, 4, number of channel words read per conversion (1..4)
DW, 12, ADC data width
RD_LOW, 3, clkin cycles rd_bar is held low per word (>=1)
RD_HIGH, 2, clkin cycles rd_bar is held high between words (>=1)
INT_LEN, 4, clkin cycles dsp_int_bar is held low per completed frame (>=1)

Ports:
clkin  in  1  system clock; all logic on the rising edge
rst_bar  in  1  asynchronous active-low reset
ad_busy  in  1  AD7864 BUSY, asynchronous to clkin, high during conversion
ad_db  in  DW  AD7864 parallel data bus
ad_cs_bar  out  1  ADC chip select, active low
ad_rd_bar  out  1  ADC read strobe, active low
dsp_addr  in  2  channel select for the read port
dsp_data  out  DW  output-buffer word at dsp_addr (combinational mux)
dsp_valid  out  1  output buffer holds an unacknowledged frame
dsp_ack  in  1  single-cycle pulse; DSP has consumed the frame
dsp_int_bar  out  1  frame-complete interrupt, active low
ovr  out  1  sticky overrun flag

Behaviour:
- Reset (async, rst_bar=0): state IDLE; ad_cs_bar=1, ad_rd_bar=1, dsp_int_bar=1, dsp_valid=0, ovr=0; shadow and output buffers=0; busy synchronizer=0; channel index=0.
- Synchronizer: ad_busy passes through 2 flops (s1 then s2), plus a prev flop. A falling edge is detected when prev=1 and s2=0.
- FSM states: IDLE, RD_LO, RD_HI, DONE.
- IDLE: ad_cs_bar=1 and ad_rd_bar=1. On a detected falling edge, go to RD_LO with channel index=0.
- RD_LO: ad_cs_bar=0 and ad_rd_bar=0 for exactly RD_LOW cycles. On the clock edge leaving RD_LO, ad_db is captured into shadow[index]. Then go to RD_HI.
- RD_HI: ad_cs_bar=0 and ad_rd_bar=1 for RD_HIGH cycles. If index==NCH-1, go to DONE; otherwise increment index and go to RD_LO.
- DONE (1 cycle): shadow is copied into the output buffer, dsp_valid is set, and an INT_LEN-cycle low pulse starts on dsp_int_bar in the following cycle. Then go to IDLE.
- Read burst length: NCH*(RD_LOW+RD_HIGH) cycles. The first ad_rd_bar fall occurs 1 cycle after the edge detect.
- dsp_ack clears dsp_valid and ovr on the next edge.
- Overrun: entering DONE while dsp_valid=1 and dsp_ack=0 sets ovr; the output buffer is still overwritten (newest data wins).
- DONE and dsp_ack in the same cycle: dsp_valid=1 and ovr=0 afterwards (the ack applies to the old frame).
- Falling BUSY edge outside IDLE (i.e. during a read burst or DONE): ignored and sets ovr; the current burst completes normally.
- INT pulse already active when a new DONE occurs: the pulse counter restarts, so dsp_int_bar stays low for INT_LEN cycles from the new DONE.
- dsp_addr >= NCH: dsp_data=0.
- Reset mid-burst: strobes go high immediately (async). The partial shadow contents are discarded and never reach the output buffer.
- Widths: index and address are 2 bits. The INT counter is sized ceil(log2(INT_LEN+1)). No arithmetic on data.

Test Plan:
1. Reset release, ad_busy pulsed high for 20 cycles then low, ad_db driving 0x111, 0x222, 0x333, 0x444 per RD_LO window -> ad_rd_bar shows 4 low pulses of 3 cycles spaced 5 cycles apart; ad_cs_bar is low for 20 cycles; dsp_valid=1; dsp_int_bar is low for 4 cycles; dsp_addr 0..3 reads 0x111/0x222/0x333/0x444.
2. Second conversion with no dsp_ack -> ovr=1 and output buffer holds the new words. dsp_ack pulse -> dsp_valid=0, ovr=0 next cycle.
3. dsp_ack asserted exactly in the DONE cycle -> afterwards dsp_valid=1, ovr=0.
4. Second BUSY falling edge injected during the 2nd RD_LO -> burst still yields 4 strobes, one DONE, ovr=1.
5. rst_bar pulsed low during the 3rd RD_LO -> ad_cs_bar and ad_rd_bar go high without waiting for a clock; after release, dsp_valid=0, buffers read 0, and the next conversion reads correctly.
6. NCH=2, RD_LOW=1, RD_HIGH=1 -> 2 strobes of 1 cycle, burst of 4 cycles; dsp_addr=2 or 3 reads 0.
